reservoir_scheduler: RTL and testbench

- Sequences the time-multiplexed delay-feedback reservoir: accepts one input sample per stream handshake, applies the per-virtual-node input mask, steps the reservoir once per virtual node, and streams each resulting node state to the readout.
- Sits between the host/DMA sample stream and the reservoir datapath. Owns the reservoir's enable and din, and owns the mask-memory read port.

---
 rtl/reservoir_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_reservoir_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservoir_scheduler.sv
// reservoir_scheduler: sequences one delay-feedback reservoir run.
// Each accepted input sample is multiplied by the per-virtual-node mask, the
// reservoir is stepped once per virtual node, and every resulting node state
// is streamed to the readout together with its node index.
// Optional build macro: RESERVOIR_WARMUP_EN -- when defined, the node states of
// the first WARMUP_SAMPLES samples of each run are not streamed (the reservoir
// is still stepped for them).
module reservoir_scheduler #(
  parameter int unsigned VIRTUAL_NODES  = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FRAC_BITS      = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned WARMUP_SAMPLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_samples,
  output logic                             busy,
  output logic                             done,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic [$clog2(VIRTUAL_NODES)-1:0] mask_addr,
  input  logic [DATA_WIDTH-1:0]            mask_data,
  output logic                             res_en,
  output logic [DATA_WIDTH-1:0]            res_din,
  input  logic [DATA_WIDTH-1:0]            res_dout,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(VIRTUAL_NODES)-1:0] m_node
);

  localparam int unsigned NODE_W = $clog2(VIRTUAL_NODES);
  localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(VIRTUAL_NODES - 1);

`ifdef RESERVOIR_WARMUP_EN
  localparam bit WARMUP_ON = 1'b1;
`else
  localparam bit WARMUP_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_S = 3'd1,
    MASK   = 3'd2,
    STEP   = 3'd3,
    OUT    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [NODE_W-1:0]       node_q, node_d;
  logic [CNT_WIDTH-1:0]    sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0]    num_samples_q, num_samples_d;
  logic [DATA_WIDTH-1:0]   s_data_q, s_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    s_ready_q, s_ready_d;
  logic                    res_en_q, res_en_d;
  logic                    m_valid_q, m_valid_d;
  logic [NODE_W-1:0]       m_node_q, m_node_d;
  logic [NODE_W-1:0]       mask_addr_q, mask_addr_d;

  logic                    advance_s;
  logic                    warm_s;
  logic [CNT_WIDTH-1:0]    cnt_inc_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic [DATA_WIDTH-1:0]   scaled_s;

  assign cnt_inc_s = sample_cnt_q + CNT_WIDTH'(1'b1);
  // Warm-up samples skip the readout; constant false in the default build.
  assign warm_s    = WARMUP_ON && (sample_cnt_q < CNT_WIDTH'(WARMUP_SAMPLES));

  // Full-precision signed product of sample and mask, then drop the mask's
  // fractional bits and truncate back to the datapath width (no saturation).
  assign prod_s   = $signed({{DATA_WIDTH{s_data_q[DATA_WIDTH-1]}}, s_data_q}) *
                    $signed({{DATA_WIDTH{mask_data[DATA_WIDTH-1]}}, mask_data});
  assign scaled_s = DATA_WIDTH'(prod_s >>> FRAC_BITS);

  // mask_data only arrives in the STEP cycle, so res_din is formed
  // combinationally there; it reads zero whenever the reservoir is not stepped.
  assign res_din = res_en_q ? scaled_s : {DATA_WIDTH{1'b0}};
  // The reservoir only moves on res_en, which is never raised in OUT, so its
  // post-step output is frozen for as long as the beat is pending.
  assign m_data  = m_valid_q ? res_dout : {DATA_WIDTH{1'b0}};

  assign busy      = busy_q;
  assign done      = done_q;
  assign s_ready   = s_ready_q;
  assign res_en    = res_en_q;
  assign m_valid   = m_valid_q;
  assign m_node    = m_node_q;
  assign mask_addr = mask_addr_q;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d       = state_q;
    node_d        = node_q;
    sample_cnt_d  = sample_cnt_q;
    num_samples_d = num_samples_q;
    s_data_d      = s_data_q;
    done_d        = 1'b0;
    advance_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_samples == {CNT_WIDTH{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            num_samples_d = num_samples;
            sample_cnt_d  = {CNT_WIDTH{1'b0}};
            node_d        = {NODE_W{1'b0}};
            state_d       = WAIT_S;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_S: begin
        if (s_valid && s_ready_q) begin
          s_data_d = s_data;
          node_d   = {NODE_W{1'b0}};
          state_d  = MASK;
        end else begin
          state_d = WAIT_S;
        end
      end
      MASK: begin
        state_d = STEP;
      end
      STEP: begin
        if (warm_s) begin
          advance_s = 1'b1;
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          advance_s = 1'b1;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Move to the next virtual node, or close the sample (and maybe the run).
    if (advance_s) begin
      if (node_q != NODE_LAST) begin
        node_d  = node_q + NODE_W'(1'b1);
        state_d = MASK;
      end else begin
        node_d       = {NODE_W{1'b0}};
        sample_cnt_d = cnt_inc_s;
        if (cnt_inc_s == num_samples_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_S;
        end
      end
    end else begin
      node_d = node_d;
    end

    busy_d      = (state_d != IDLE);
    s_ready_d   = (state_d == WAIT_S);
    res_en_d    = (state_d == STEP);
    m_valid_d   = (state_d == OUT);
    m_node_d    = (state_d == OUT)  ? node_d : m_node_q;
    mask_addr_d = (state_d == MASK) ? node_d : mask_addr_q;
  end

  // State, counters and output registers; async reset abandons any partial run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      node_q        <= {NODE_W{1'b0}};
      sample_cnt_q  <= {CNT_WIDTH{1'b0}};
      num_samples_q <= {CNT_WIDTH{1'b0}};
      s_data_q      <= {DATA_WIDTH{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      s_ready_q     <= 1'b0;
      res_en_q      <= 1'b0;
      m_valid_q     <= 1'b0;
      m_node_q      <= {NODE_W{1'b0}};
      mask_addr_q   <= {NODE_W{1'b0}};
    end else begin
      state_q       <= state_d;
      node_q        <= node_d;
      sample_cnt_q  <= sample_cnt_d;
      num_samples_q <= num_samples_d;
      s_data_q      <= s_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      s_ready_q     <= s_ready_d;
      res_en_q      <= res_en_d;
      m_valid_q     <= m_valid_d;
      m_node_q      <= m_node_d;
      mask_addr_q   <= mask_addr_d;
    end
  end

endmodule

// File: tb/tb_reservoir_scheduler.sv
// Self-checking bench for reservoir_scheduler: a scoreboard predicts every
// reservoir step input and every node-state beat from the sample/mask values,
// a stand-in reservoir accumulates its inputs, and directed tests pin timing.
module tb_reservoir_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = 16'd0;
  logic        busy, done, s_ready, res_en, m_valid;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic [3:0]  mask_addr, m_node;
  logic [31:0] mask_data = 32'd0;
  logic [31:0] res_din, res_dout, m_data;
  logic        m_ready = 1'b1;

  reservoir_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mask_addr(mask_addr), .mask_data(mask_data),
    .res_en(res_en), .res_din(res_din), .res_dout(res_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_node(m_node)
  );

  always #5 clk = ~clk;

`ifdef RESERVOIR_WARMUP_EN
  localparam int LAT1  = 21;
  localparam int BP_NS = 6;
`else
  localparam int LAT1  = 31;
  localparam int BP_NS = 2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mask memory with one cycle of read latency.
  logic [31:0] mask_mem [10];
  always @(posedge clk) mask_data <= (mask_addr < 4'd10) ? mask_mem[mask_addr] : 32'hDEADBEEF;

  // Stand-in reservoir: each step adds its input plus one.
  logic [31:0] res_q;
  always @(posedge clk or negedge rst)
    if (!rst) res_q <= 32'd0;
    else if (res_en) res_q <= res_q + res_din + 32'd1;
  assign res_dout = res_q;

  // ---------------- behavioural model / scoreboard ----------------
  typedef struct { int node; logic [31:0] data; int samp; } beat_t;
  beat_t       exp_q[$];
  logic [31:0] din_q[$];
  logic [31:0] model_acc = 32'd0;
  int          model_samp = 0;
  int          first_samp = -1;
  int          hs_cyc = 0, din_idx = 0;
  int          n_res_en = 0, n_beats = 0, stall_cycles = 0;
  logic [31:0] din_log [10];
  logic [31:0] last_data = 32'd0;
  int          last_node = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic [3:0]  prev_node = 4'd0;

  function automatic logic [31:0] scale(input logic [31:0] s, input logic [31:0] m);
    longint a, b, p;
    a = longint'($signed(s));
    b = longint'($signed(m));
    p = a * b;
    return 32'(p >>> 16);
  endfunction

  function automatic int beats_for(input int ns);
`ifdef RESERVOIR_WARMUP_EN
    return (ns > 4) ? (ns - 4) * 10 : 0;
`else
    return ns * 10;
`endif
  endfunction

  // Compare process: checks DUT outputs against the model at every negedge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      din_q.delete();
      model_acc  = 32'd0;
      prev_stall = 1'b0;
    end else begin
      if (start && !busy && num_samples != 16'd0) begin
        model_samp = 0;
        first_samp = -1;
      end
      if (s_valid && s_ready) begin
        hs_cyc  = cyc;
        din_idx = 0;
        for (int n = 0; n < 10; n++) begin
          logic [31:0] d;
          beat_t b;
          d = scale(s_data, mask_mem[n]);
          din_q.push_back(d);
          model_acc = model_acc + d + 32'd1;
          b.node = n; b.data = model_acc; b.samp = model_samp;
`ifdef RESERVOIR_WARMUP_EN
          if (model_samp >= 4) exp_q.push_back(b);
`else
          exp_q.push_back(b);
`endif
        end
        model_samp++;
      end
      if (res_en) begin
        if (din_q.size() == 0) check("res_en_unexpected", 1, 0);
        else check("res_din", res_din, din_q.pop_front());
        din_log[din_idx % 10] = res_din;
        din_idx++;
        n_res_en++;
      end
      if (m_valid) begin
        check("res_en_during_out", res_en, 0);
        check("s_ready_during_out", s_ready, 0);
        if (prev_stall) begin
          check("stall_m_data_stable", m_data, prev_data);
          check("stall_m_node_stable", m_node, prev_node);
        end
        if (m_ready) begin
          if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
          else begin
            beat_t b;
            b = exp_q.pop_front();
            check("m_node", m_node, 64'(b.node));
            check("m_data", m_data, b.data);
            if (first_samp < 0) first_samp = b.samp;
          end
          n_beats++;
          last_data = m_data;
          last_node = int'(m_node);
        end else stall_cycles++;
      end
      check("mask_addr_range", mask_addr <= 4'd9, 1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_node  = m_node;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [15:0] n);
    num_samples = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_sample(input logic [31:0] d);
    bit ok = 1'b0;
    s_data = d; s_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("s_handshake_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; dc = cyc; break; end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic set_masks_unity();
    for (int i = 0; i < 10; i++) mask_mem[i] = 32'h00010000;
  endtask

  task automatic stall_at_node4();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_node == 4'd3) begin ok = 1'b1; break; end
    end
    check("bp_reach_node3", ok, 1);
    tick();
    m_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) begin ok = 1'b1; break; end
    end
    check("bp_stall_valid", ok, 1);
    check("bp_stall_node", m_node, 4);
    repeat (4) @(negedge clk);
    check("bp_still_valid", m_valid, 1);
    tick();
    m_ready = 1'b1;
  endtask

  // Watchdog so a hung design still ends the run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int dc, b0, r0, st0;
  logic [31:0] mix_masks [10];
  initial begin
    mix_masks = '{32'h00010000, 32'hFFFF0000, 32'h00008000, 32'h00020000, 32'hFFFF8000,
                  32'h00000001, 32'h7FFFFFFF, 32'h80000000, 32'h00003000, 32'hFFFFFFFF};
    set_masks_unity();

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_s_ready", s_ready, 0); check("rst_res_en", res_en, 0);
    check("rst_m_valid", m_valid, 0); check("rst_res_din", res_din, 0);
    check("rst_m_data", m_data, 0);   check("rst_m_node", m_node, 0);
    check("rst_mask_addr", mask_addr, 0);
    tick(); rst = 1'b1; tick();

    // Single sample, unity masks, 0.5 input.
    b0 = n_beats; r0 = n_res_en;
    start_run(16'd1);
    send_sample(32'h00008000);
    wait_done(dc);
    check("t2_res_en_count", n_res_en - r0, 10);
    check("t2_beats", n_beats - b0, beats_for(1));
    check("t2_done_latency", dc - hs_cyc, LAT1);
    check("t2_din_node0", din_log[0], 32'h00008000);
    check("t2_din_node9", din_log[9], 32'h00008000);
`ifndef RESERVOIR_WARMUP_EN
    check("t2_last_beat_data", last_data, 32'h0005000A);
    check("t2_last_beat_node", last_node, 9);
`endif
    @(negedge clk);
    check("t2_done_one_cycle", done, 0);
    check("t2_busy_after", busy, 0);
    check("t2_queue_empty", exp_q.size() + din_q.size(), 0);

    // Negative mask on node 3 only.
    mask_mem[3] = 32'hFFFF0000;
    start_run(16'd1);
    send_sample(32'h00020000);
    wait_done(dc);
    check("t3_din_node3", din_log[3], 32'hFFFE0000);
    check("t3_din_node4", din_log[4], 32'h00020000);
    check("t3_din_node2", din_log[2], 32'h00020000);

    // Backpressure at node 4.
    b0 = n_beats; st0 = stall_cycles;
    fork
      begin
        start_run(16'(BP_NS));
        for (int i = 0; i < BP_NS; i++) send_sample(32'h00011000 + 32'(i));
        wait_done(dc);
      end
      stall_at_node4();
    join
    check("t4_stall_cycles", stall_cycles - st0, 5);
    check("t4_beats", n_beats - b0, beats_for(BP_NS));

    // num_samples = 0.
    start_run(16'd0);
    @(negedge clk);
    check("t5_zero_done", done, 1);
    check("t5_zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_zero_busy_idle", busy, 0);
      check("t5_zero_s_ready", s_ready, 0);
      check("t5_zero_done_low", done, 0);
    end

    // start while busy is ignored.
    b0 = n_beats; r0 = n_res_en;
    start_run(16'd2);
    send_sample(32'h00004000);
    num_samples = 16'd5; start = 1'b1; tick(); start = 1'b0;
    send_sample(32'hFFFFC000);
    wait_done(dc);
    check("t5b_res_en_count", n_res_en - r0, 20);
    check("t5b_beats", n_beats - b0, beats_for(2));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5b_idle_s_ready", s_ready, 0);
      check("t5b_idle_busy", busy, 0);
    end

    // Mixed signed masks with a toggling readout.
    for (int i = 0; i < 10; i++) mask_mem[i] = mix_masks[i];
    b0 = n_beats;
    fork
      begin
        start_run(16'd3);
        send_sample(32'h00018000);
        send_sample(32'hFFFF4000);
        send_sample(32'h7FFF0000);
        wait_done(dc);
      end
      begin
        for (int i = 0; i < 150; i++) begin m_ready = (i % 3 != 1); tick(); end
        m_ready = 1'b1;
      end
    join
    check("t6_beats", n_beats - b0, beats_for(3));
    check("t6_queue_empty", exp_q.size() + din_q.size(), 0);

`ifdef RESERVOIR_WARMUP_EN
    // Warm-up: six samples, first four discarded.
    b0 = n_beats; r0 = n_res_en;
    start_run(16'd6);
    for (int i = 0; i < 6; i++) send_sample(32'h00010000 + 32'(i << 12));
    wait_done(dc);
    check("wu_res_en_count", n_res_en - r0, 60);
    check("wu_beats", n_beats - b0, 20);
    check("wu_first_beat_sample", first_samp, 4);
`endif

    // Reset in the middle of a STEP cycle.
    set_masks_unity();
    start_run(16'd1);
    send_sample(32'h00030000);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (res_en) begin ok = 1'b1; break; end
      end
      check("t7_reach_step", ok, 1);
    end
    #2 rst = 1'b0;
    #1;
    check("t7_res_en", res_en, 0);   check("t7_m_valid", m_valid, 0);
    check("t7_busy", busy, 0);       check("t7_s_ready", s_ready, 0);
    check("t7_res_din", res_din, 0); check("t7_mask_addr", mask_addr, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    b0 = n_beats; r0 = n_res_en;
    start_run(16'd1);
    send_sample(32'h00010000);
    wait_done(dc);
    check("t7_after_res_en", n_res_en - r0, 10);
    check("t7_after_beats", n_beats - b0, beats_for(1));
    check("t7_after_latency", dc - hs_cyc, LAT1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
